// File: rtl/lab2_g29_pkg.sv
// Shared types and defaults for the lab2 sweep controller.
// The state encoding is also visible on the debug port of the interface.
package lab2_g29_pkg;

  localparam int N_IN_DEF  = 4;
  localparam int DWELL_DEF = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    FINISH  = 2'd3
  } state_t;

endpackage

// File: rtl/lab2_g29_sweep_ctrl_if.sv
// Signal bundle between the sweep controller and the board / function under test.
// The master modport is the controller; the slave modport is everything around it.
interface lab2_g29_sweep_ctrl_if
  import lab2_g29_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
) ();

  localparam int DEPTH = 1 << N_IN;

  // Handshake: start is a level sampled only while idle (abort overrides it);
  // done is a one-cycle pulse, after which match and err_cnt hold the result.
  logic             start;
  logic             abort;
  logic [DEPTH-1:0] golden;
  logic             y;
  logic [N_IN-1:0]  vec;
  logic             busy;
  logic             done;
  logic             match;
  logic [N_IN:0]    err_cnt;
  logic [DEPTH-1:0] table_q;
  state_t           state;

  modport master (
    input  start, abort, golden, y,
    output vec, busy, done, match, err_cnt, table_q, state
  );

  modport slave (
    output start, abort, golden, y,
    input  vec, busy, done, match, err_cnt, table_q, state
  );

endinterface

// File: rtl/lab2_g29_sweep_ctrl.sv
// Walks every input vector of a small combinational function, holds each one for
// DWELL cycles, records the response and counts disagreements with a golden table.
module lab2_g29_sweep_ctrl
  import lab2_g29_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  lab2_g29_sweep_ctrl_if.master bus
);

  localparam int              DEPTH    = 1 << N_IN;
  localparam logic [7:0]      DWELL_M1 = 8'(DWELL - 1);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  state_t           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [DEPTH-1:0] golden_q, golden_d;
  logic [DEPTH-1:0] table_q, table_d;
  logic [N_IN:0]    err_cnt_q, err_cnt_d;
  logic             match_q, match_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    golden_d  = golden_q;
    table_d   = table_q;
    err_cnt_d = err_cnt_q;
    match_d   = match_q;

    // Abort drops straight to idle; partial table and count are kept for inspection.
    if (state_q != IDLE && bus.abort) begin
      state_d = IDLE;
      vec_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            golden_d  = bus.golden;
            err_cnt_d = '0;
            table_d   = '0;
            match_d   = 1'b0;
            vec_d     = '0;
            cnt_d     = '0;
            state_d   = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == DWELL_M1) begin
            state_d = CAPTURE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        CAPTURE: begin
          table_d[vec_q] = bus.y;
          if (bus.y != golden_q[vec_q]) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          if (vec_q == VEC_LAST) begin
            state_d = FINISH;
          end else begin
            vec_d   = vec_q + 1'b1;
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
        FINISH: begin
          match_d = (err_cnt_q == '0);
          vec_d   = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      cnt_q     <= '0;
      golden_q  <= '0;
      table_q   <= '0;
      err_cnt_q <= '0;
      match_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      golden_q  <= golden_d;
      table_q   <= table_d;
      err_cnt_q <= err_cnt_d;
      match_q   <= match_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.vec     = vec_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.match   = match_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.table_q = table_q;
  assign bus.state   = state_q;

endmodule
